// File: rtl/decode_pkg.sv
// decode_pkg: control-word layout, branch kinds and field widths shared by the decode stage
package decode_pkg;

    localparam int SHAMT_W = 5;

    typedef enum logic [2:0] {
        BR_NONE,
        BR_EQ,
        BR_NE,
        BR_LEZ,
        BR_GTZ
    } br_kind_e;

    typedef struct packed {
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] alu_src;
        logic [3:0] alu_control;
        logic [2:0] jump;
        logic       mem_write;
        logic       mem_to_reg;
        br_kind_e   branch;
    } ctrl_t;

endpackage

// File: rtl/decode_hazard.sv
// decode_hazard: load-use / branch stall detection and M-stage forwarding of branch compare operands
module decode_hazard
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic [RA_W-1:0]   rs_i,
    input  logic [RA_W-1:0]   rt_i,
    input  logic              br_d_i,
    input  logic [DATA_W-1:0] rd1_i,
    input  logic [DATA_W-1:0] rd2_i,
    input  logic              valid_e_i,
    input  logic              reg_write_e_i,
    input  logic              mem_to_reg_e_i,
    input  logic [RA_W-1:0]   dst_e_i,
    input  logic              reg_write_m_i,
    input  logic              mem_to_reg_m_i,
    input  logic [RA_W-1:0]   dst_m_i,
    input  logic [DATA_W-1:0] alu_out_m_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] cmp_a_o,
    output logic [DATA_W-1:0] cmp_b_o
);

    logic hit_e, hit_m;

    always_comb begin
        hit_e   = (dst_e_i != '0) && (dst_e_i == rs_i || dst_e_i == rt_i);
        hit_m   = (dst_m_i != '0) && (dst_m_i == rs_i || dst_m_i == rt_i);
        // a loaded value in M is not ready for the branch compare until it leaves M
        stall_o = (valid_e_i & mem_to_reg_e_i & hit_e)
                | (valid_e_i & reg_write_e_i & br_d_i & hit_e)
                | (mem_to_reg_m_i & br_d_i & hit_m);
        cmp_a_o = (reg_write_m_i && dst_m_i != '0 && dst_m_i == rs_i) ? alu_out_m_i : rd1_i;
        cmp_b_o = (reg_write_m_i && dst_m_i != '0 && dst_m_i == rt_i) ? alu_out_m_i : rd2_i;
    end

endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: decode stage with early branch resolution, hazard stalling and the D->E pipeline register
module decode_pipe
    import decode_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  REG_N  = 32,
    parameter int  CNT_W  = 16,
    localparam int RA_W   = $clog2(REG_N)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_d_i,
    output logic               ready_d_o,
    input  logic [31:0]        instr_d_i,
    input  logic [DATA_W-1:0]  pc_plus_4_d_i,
    input  ctrl_t              ctrl_d_i,
    input  logic [DATA_W-1:0]  rd1_d_i,
    input  logic [DATA_W-1:0]  rd2_d_i,
    input  logic               reg_write_m_i,
    input  logic               mem_to_reg_m_i,
    input  logic [RA_W-1:0]    dst_m_i,
    input  logic [DATA_W-1:0]  alu_out_m_i,
    input  logic               ready_e_i,
    input  logic               flush_e_i,
    output logic               pc_src_d_o,
    output logic [DATA_W-1:0]  pc_branch_d_o,
    output logic               valid_e_o,
    output ctrl_t              ctrl_e_o,
    output logic [DATA_W-1:0]  reg_data_1_e_o,
    output logic [DATA_W-1:0]  reg_data_2_e_o,
    output logic [RA_W-1:0]    rs_e_o,
    output logic [RA_W-1:0]    rt_e_o,
    output logic [RA_W-1:0]    rd_e_o,
    output logic [SHAMT_W-1:0] shamt_e_o,
    output logic [DATA_W-1:0]  sign_imm_e_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    typedef struct packed {
        ctrl_t              ctrl;
        logic [DATA_W-1:0]  rd1;
        logic [DATA_W-1:0]  rd2;
        logic [RA_W-1:0]    rs;
        logic [RA_W-1:0]    rt;
        logic [RA_W-1:0]    rd;
        logic [SHAMT_W-1:0] shamt;
        logic [DATA_W-1:0]  imm;
    } e_reg_t;

    e_reg_t            e_q, e_d, e_new;
    logic              valid_e_q, valid_e_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [RA_W-1:0]   dst_e;
    logic [DATA_W-1:0] cmp_a, cmp_b;
    logic              stall, fire, a_lez, taken;
    logic              unused_opcode;

    assign unused_opcode = ^{instr_d_i[31:26], instr_d_i[5:0]};

    always_comb begin
        e_new.ctrl  = ctrl_d_i;
        e_new.rd1   = rd1_d_i;
        e_new.rd2   = rd2_d_i;
        e_new.rs    = RA_W'(instr_d_i[25:21]);
        e_new.rt    = RA_W'(instr_d_i[20:16]);
        e_new.rd    = RA_W'(instr_d_i[15:11]);
        e_new.shamt = instr_d_i[10:6];
        e_new.imm   = {{(DATA_W-16){instr_d_i[15]}}, instr_d_i[15:0]};
        dst_e       = e_q.ctrl.reg_dst ? e_q.rd : e_q.rt;
    end

    decode_hazard #(.DATA_W(DATA_W), .RA_W(RA_W)) u_hazard (
        .rs_i           (e_new.rs),
        .rt_i           (e_new.rt),
        .br_d_i         (ctrl_d_i.branch != BR_NONE),
        .rd1_i          (rd1_d_i),
        .rd2_i          (rd2_d_i),
        .valid_e_i      (valid_e_q),
        .reg_write_e_i  (e_q.ctrl.reg_write),
        .mem_to_reg_e_i (e_q.ctrl.mem_to_reg),
        .dst_e_i        (dst_e),
        .reg_write_m_i  (reg_write_m_i),
        .mem_to_reg_m_i (mem_to_reg_m_i),
        .dst_m_i        (dst_m_i),
        .alu_out_m_i    (alu_out_m_i),
        .stall_o        (stall),
        .cmp_a_o        (cmp_a),
        .cmp_b_o        (cmp_b)
    );

    always_comb begin
        ready_d_o     = ~stall & (ready_e_i | ~valid_e_q);
        fire          = valid_d_i & ready_d_o;
        a_lez         = cmp_a[DATA_W-1] | ~|cmp_a;
        taken         = (ctrl_d_i.branch == BR_EQ)  ? cmp_a == cmp_b :
                        (ctrl_d_i.branch == BR_NE)  ? cmp_a != cmp_b :
                        (ctrl_d_i.branch == BR_LEZ) ? a_lez :
                        (ctrl_d_i.branch == BR_GTZ) & ~a_lez;
        pc_src_d_o    = fire & taken;
        pc_branch_d_o = pc_plus_4_d_i + {e_new.imm[DATA_W-3:0], 2'b00};
        valid_e_d     = flush_e_i ? 1'b0 : fire ? 1'b1 : ~ready_e_i & valid_e_q;
        e_d           = (~flush_e_i & fire) ? e_new : e_q;
        stall_cnt_d   = stall_cnt_q + CNT_W'(valid_d_i & stall & ~&stall_cnt_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_e_q   <= 1'b0;
            e_q         <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_e_q   <= valid_e_d;
            e_q         <= e_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign valid_e_o      = valid_e_q;
    assign ctrl_e_o       = e_q.ctrl;
    assign reg_data_1_e_o = e_q.rd1;
    assign reg_data_2_e_o = e_q.rd2;
    assign rs_e_o         = e_q.rs;
    assign rt_e_o         = e_q.rt;
    assign rd_e_o         = e_q.rd;
    assign shamt_e_o      = e_q.shamt;
    assign sign_imm_e_o   = e_q.imm;
    assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter DATA_W, default 32, datapath and register-data width.
REQ-002 Parameter REG_N, default 32, architectural register count; RA_W = clog2(REG_N).
REQ-003 Parameter CNT_W, default 16, stall-counter width.
REQ-004 The block SHALL have one clock, clk_i, and a synchronous active-high reset, rst_i.
REQ-005 Ports, as name / direction / width / meaning:
  clk_i  in  1  clock
  rst_i  in  1  synchronous active-high reset
  valid_d_i  in  1  fetch presents an instruction
  ready_d_o  out  1  decode accepts this cycle
  instr_d_i  in  32  instruction word
  pc_plus_4_d_i  in  DATA_W  PC+4 of the instruction
  ctrl_d_i  in  ctrl_t  decoded control word from control_unit
  rd1_d_i / rd2_d_i  in  DATA_W  register-file reads of rs / rt
  reg_write_m_i, mem_to_reg_m_i  in  1 each  M-stage control
  dst_m_i  in  RA_W  M-stage destination
  alu_out_m_i  in  DATA_W  M-stage ALU result
  ready_e_i  in  1  execute accepts
  flush_e_i  in  1  kill E-register contents
  pc_src_d_o  out  1  branch taken
  pc_branch_d_o  out  DATA_W  branch target
  valid_e_o  out  1  E register holds a live instruction
  ctrl_e_o  out  ctrl_t  registered control word
  reg_data_1_e_o / reg_data_2_e_o  out  DATA_W  registered operands
  rs_e_o / rt_e_o / rd_e_o  out  RA_W  registered register fields
  shamt_e_o  out  5  registered shift amount
  sign_imm_e_o  out  DATA_W  registered sign-extended immediate
  stall_cnt_o  out  CNT_W  saturating hazard-stall count

Function
REQ-006 rs = instr[25:21], rt = instr[20:16], rd = instr[15:11], shamt = instr[10:6], sign_imm = instr[15:0] sign-extended to DATA_W.
REQ-007 pc_branch_d_o SHALL equal pc_plus_4_d_i + (sign_imm << 2), computed modulo 2^DATA_W.
REQ-008 Compare operands SHALL be forwarded: use alu_out_m_i when reg_write_m_i = 1, dst_m_i != 0 and dst_m_i equals the source field; otherwise use rd1_d_i / rd2_d_i.
REQ-009 Branch kinds BR_NONE, BR_EQ, BR_NE, BR_LEZ and BR_GTZ SHALL be supported; LEZ and GTZ test operand A as signed.
REQ-010 pc_src_d_o SHALL be 1 only when valid_d_i = 1, ready_d_o = 1 and the condition holds.
REQ-011 dst_e = reg_dst_e ? rd_e_o : rt_e_o. A hazard match requires dst != 0 and dst equal to rs or rt.
REQ-012 Stall SHALL assert when valid_e_o = 1, mem_to_reg_e = 1 and dst_e matches (load-use).
REQ-013 Stall SHALL assert when valid_e_o = 1, reg_write_e = 1, the D instruction is a branch and dst_e matches.
REQ-014 Stall SHALL assert when mem_to_reg_m_i = 1, the D instruction is a branch and dst_m_i matches.
REQ-015 ready_d_o = ~stall & (ready_e_i | ~valid_e_o). ready_d_o is combinational and SHALL NOT depend on valid_d_i.
REQ-016 E-register update priority: flush_e_i clears valid_e_o; otherwise a fire (valid_d_i & ready_d_o) loads all fields and sets valid_e_o; otherwise ready_e_i clears valid_e_o (bubble); otherwise all fields hold.
REQ-017 While valid_e_o = 1 and ready_e_i = 0, every E output SHALL stay stable.
REQ-018 stall_cnt_o SHALL increment once per cycle with valid_d_i & stall, and saturate at all-ones.
REQ-019 Latency: an accepted instruction SHALL appear on the E outputs the following cycle.

Reset
REQ-020 On rst_i, valid_e_o, ctrl_e_o, all data and field outputs, and stall_cnt_o SHALL be 0 on the next edge. Reset takes priority over flush and fire, including mid-stall.

Structure
REQ-021 ctrl_t (packed: reg_write, reg_dst, alu_src[1:0], alu_control[3:0], jump[2:0], mem_write, mem_to_reg, branch kind), the branch-kind enum and the shamt width SHALL live in a shared package, decode_pkg.
REQ-022 One sub-module, decode_hazard (stall detection and compare forwarding, combinational), is natural; the E register stays in decode_pipe.

Verification
REQ-023 Test: lw $2 in E, then add $3,$2,$4 with valid_d_i = 1 → ready_d_o = 0 for 1 cycle, stall_cnt_o +1, then add enters E with valid_e_o = 1.
REQ-024 Test: beq $1,$1,+3 at PC+4 = 0x100, no hazards → pc_src_d_o = 1 and pc_branch_d_o = 0x10C in the fire cycle.
REQ-025 Test: M writes $5 = 7, branch bne $5,$0 in D, rd1_d_i = 0 → forwarded operand is used and pc_src_d_o = 1.
REQ-026 Test: ready_e_i = 0 for 3 cycles while valid_e_o = 1 → E outputs unchanged and ready_d_o = 0; fire resumes when ready_e_i = 1.
REQ-027 Test: flush_e_i and fire in the same cycle → valid_e_o = 0 next cycle. rst_i asserted mid-stall → all outputs 0 next cycle.
REQ-028 Test: 2^CNT_W + 2 stall cycles → stall_cnt_o saturates at all-ones.
